// File: rtl/tdm_demux_pkg.sv
// Shared definitions for the TDM multiplexer family: FSM state encodings
// and the slot-counter width helper used by the demux and the planned mux.
package tdm_demux_pkg;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  localparam int MIN_NCH = 2;
  localparam int MAX_NCH = 16;

  // ceil(log2(n)), never below 1 so a two-channel frame still gets a 1-bit slot.
  function automatic int slot_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/tdm_demux_mod_counter.sv
// Modulo-MOD wrapping counter. load0 restarts the sequence at 0; if en is
// asserted in the same cycle the restart counts as the first step (count=1).
module mod_counter
  import tdm_demux_pkg::*;
#(
  parameter int MOD = 4,
  parameter int W   = slot_width(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load0,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] base;
  logic [W-1:0] count_nxt;

  // Wrap is decided by compare so non-power-of-two MOD works.
  always_comb begin
    base      = load0 ? '0 : count;
    count_nxt = base;
    if (en) begin
      count_nxt = (base == LAST) ? '0 : base + 1'b1;
    end
  end

  assign wrap = (count == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: locks onto frame_start, steers each valid
// sample into its channel register and flags frame-alignment errors.
module tdm_demux
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_start,
  output logic [NCH*WIDTH-1:0] ch_data,
  output logic [NCH-1:0]       ch_valid,
  output logic                 frame_done,
  output logic                 locked,
  output logic                 sync_err
);

  localparam int SW = slot_width(NCH);

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] slot;
  logic          slot_last;
  logic          cnt_en;
  logic          cnt_load0;
  logic          cap;
  logic [SW-1:0] cap_ch;
  logic          done_nxt;
  logic          err_nxt;

  mod_counter #(
    .MOD (NCH),
    .W   (SW)
  ) u_slot (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .load0 (cnt_load0),
    .count (slot),
    .wrap  (slot_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case/if tree can leave a value unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_HUNT: begin
        if (din_valid && frame_start) state_nxt = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (din_valid && !frame_start && slot == '0) state_nxt = ST_HUNT;
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  // A frame_start sample always lands in channel 0 and restarts the slot
  // sequence at 1; only a missing frame_start at slot 0 drops back to HUNT.
  always_comb begin
    cap       = 1'b0;
    cap_ch    = '0;
    cnt_en    = 1'b0;
    cnt_load0 = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (din_valid) begin
      case (state)
        ST_HUNT: begin
          if (frame_start) begin
            cap       = 1'b1;
            cnt_load0 = 1'b1;
            cnt_en    = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (frame_start) begin
            cap       = 1'b1;
            cnt_load0 = 1'b1;
            cnt_en    = 1'b1;
            err_nxt   = (slot != '0);
          end else if (slot == '0) begin
            cnt_load0 = 1'b1;
            err_nxt   = 1'b1;
          end else begin
            cap      = 1'b1;
            cap_ch   = slot;
            cnt_en   = 1'b1;
            done_nxt = slot_last;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the channel registers are reset because a mid-frame reset must
  // visibly clear stale samples, not merely stop updating them.
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_valid   <= '0;
      frame_done <= done_nxt;
      sync_err   <= err_nxt;
      for (int k = 0; k < NCH; k++) begin
        if (cap && cap_ch == SW'(k)) begin
          ch_data[k*WIDTH +: WIDTH] <= din;
          ch_valid[k]               <= 1'b1;
        end
      end
    end
  end

  assign locked = (state == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux: a 4-channel instance for the main scenarios
// and a 3-channel instance for the non-power-of-two wrap.
module tb_tdm_demux;

  logic        clk;
  logic        rst;

  logic [7:0]  d4;
  logic        v4;
  logic        fs4;
  logic [31:0] ch_data4;
  logic [3:0]  ch_valid4;
  logic        done4;
  logic        locked4;
  logic        err4;

  logic [7:0]  d3;
  logic        v3;
  logic        fs3;
  logic [23:0] ch_data3;
  logic [2:0]  ch_valid3;
  logic        done3;
  logic        locked3;
  logic        err3;

  int n_vec;
  int n_err;

  tdm_demux #(.WIDTH(8), .NCH(4)) dut4 (
    .clk         (clk),
    .rst         (rst),
    .din         (d4),
    .din_valid   (v4),
    .frame_start (fs4),
    .ch_data     (ch_data4),
    .ch_valid    (ch_valid4),
    .frame_done  (done4),
    .locked      (locked4),
    .sync_err    (err4)
  );

  tdm_demux #(.WIDTH(8), .NCH(3)) dut3 (
    .clk         (clk),
    .rst         (rst),
    .din         (d3),
    .din_valid   (v3),
    .frame_start (fs3),
    .ch_data     (ch_data3),
    .ch_valid    (ch_valid3),
    .frame_done  (done3),
    .locked      (locked3),
    .sync_err    (err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 ns after a rising edge; outputs are read at the same point.
  task automatic cyc4(input logic [7:0] d, input logic v, input logic fs);
    d4 = d; v4 = v; fs4 = fs;
    @(posedge clk); #1;
    v4 = 1'b0; fs4 = 1'b0;
  endtask

  task automatic cyc3(input logic [7:0] d, input logic v, input logic fs);
    d3 = d; v3 = v; fs3 = fs;
    @(posedge clk); #1;
    v3 = 1'b0; fs3 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({ch_data4, ch_valid4, done4, locked4, err4} !== 40'h0) begin
      n_err++;
      $display("FAIL reset4: got data=%h valid=%b done=%b locked=%b err=%b want all 0",
               ch_data4, ch_valid4, done4, locked4, err4);
    end
    n_vec++;
    if ({ch_data3, ch_valid3, done3, locked3, err3} !== 30'h0) begin
      n_err++;
      $display("FAIL reset3: got data=%h valid=%b done=%b locked=%b err=%b want all 0",
               ch_data3, ch_valid3, done3, locked3, err3);
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    logic [7:0] samples [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [3:0] exp_v   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc4(samples[i], 1'b1, i == 0);
      n_vec++;
      if (ch_valid4 !== exp_v[i] || done4 !== (i == 3) || err4 !== 1'b0 || locked4 !== 1'b1) begin
        n_err++;
        $display("FAIL nominal_%0d: got valid=%b done=%b err=%b locked=%b want valid=%b done=%b err=0 locked=1",
                 i, ch_valid4, done4, err4, locked4, exp_v[i], i == 3);
      end
    end
    n_vec++;
    if (ch_data4 !== 32'h13121110) begin
      n_err++;
      $display("FAIL nominal_data: got %h want 13121110", ch_data4);
    end
    cyc4(8'h00, 1'b0, 1'b0);
    n_vec++;
    if (ch_valid4 !== 4'b0000 || done4 !== 1'b0) begin
      n_err++;
      $display("FAIL nominal_idle: got valid=%b done=%b want 0000/0", ch_valid4, done4);
    end
  endtask

  task automatic test_gaps();
    logic [7:0] samples [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    logic [3:0] exp_v   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    int         pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      cyc4(samples[i], 1'b1, i == 0);
      n_vec++;
      if (ch_valid4 !== exp_v[i] || done4 !== (i == 3)) begin
        n_err++;
        $display("FAIL gaps_%0d: got valid=%b done=%b want valid=%b done=%b",
                 i, ch_valid4, done4, exp_v[i], i == 3);
      end
      for (int g = 0; g < 3; g++) begin
        cyc4(8'hEE, 1'b0, 1'b1);
        if (ch_valid4 !== 4'b0000 || done4 !== 1'b0 || err4 !== 1'b0) pulses++;
      end
    end
    n_vec++;
    if (pulses !== 0) begin
      n_err++;
      $display("FAIL gaps_idle: got %0d idle cycles with pulses want 0", pulses);
    end
    n_vec++;
    if (ch_data4 !== 32'h13121110 || locked4 !== 1'b1) begin
      n_err++;
      $display("FAIL gaps_data: got data=%h locked=%b want 13121110/1", ch_data4, locked4);
    end
  endtask

  task automatic test_hunt_discard();
    do_reset();
    cyc4(8'hAA, 1'b1, 1'b0);
    cyc4(8'hBB, 1'b1, 1'b0);
    n_vec++;
    if (ch_valid4 !== 4'b0000 || ch_data4 !== 32'h0 || locked4 !== 1'b0 || err4 !== 1'b0) begin
      n_err++;
      $display("FAIL hunt_discard: got valid=%b data=%h locked=%b err=%b want 0000/0/0/0",
               ch_valid4, ch_data4, locked4, err4);
    end
    cyc4(8'h50, 1'b1, 1'b1);
    n_vec++;
    if (ch_valid4 !== 4'b0001 || ch_data4 !== 32'h00000050 || locked4 !== 1'b1) begin
      n_err++;
      $display("FAIL hunt_lock: got valid=%b data=%h locked=%b want 0001/00000050/1",
               ch_valid4, ch_data4, locked4);
    end
  endtask

  task automatic test_early_fs();
    do_reset();
    cyc4(8'h20, 1'b1, 1'b1);
    cyc4(8'h21, 1'b1, 1'b0);
    cyc4(8'h30, 1'b1, 1'b1);
    n_vec++;
    if (err4 !== 1'b1 || ch_valid4 !== 4'b0001 || done4 !== 1'b0 ||
        ch_data4 !== 32'h00002130 || locked4 !== 1'b1) begin
      n_err++;
      $display("FAIL early_fs: got err=%b valid=%b done=%b data=%h locked=%b want 1/0001/0/00002130/1",
               err4, ch_valid4, done4, ch_data4, locked4);
    end
    cyc4(8'h31, 1'b1, 1'b0);
    n_vec++;
    if (err4 !== 1'b0 || ch_valid4 !== 4'b0010 || ch_data4 !== 32'h00003130) begin
      n_err++;
      $display("FAIL early_resync: got err=%b valid=%b data=%h want 0/0010/00003130",
               err4, ch_valid4, ch_data4);
    end
    cyc4(8'h32, 1'b1, 1'b0);
    cyc4(8'h33, 1'b1, 1'b1);
    n_vec++;
    if (err4 !== 1'b1 || done4 !== 1'b0 || ch_valid4 !== 4'b0001 || ch_data4 !== 32'h00323133) begin
      n_err++;
      $display("FAIL early_last_slot: got err=%b done=%b valid=%b data=%h want 1/0/0001/00323133",
               err4, done4, ch_valid4, ch_data4);
    end
  endtask

  task automatic test_missing_fs();
    do_reset();
    cyc4(8'h30, 1'b1, 1'b1);
    cyc4(8'h31, 1'b1, 1'b0);
    cyc4(8'h32, 1'b1, 1'b0);
    cyc4(8'h33, 1'b1, 1'b0);
    cyc4(8'h40, 1'b1, 1'b0);
    n_vec++;
    if (err4 !== 1'b1 || locked4 !== 1'b0 || ch_valid4 !== 4'b0000 || ch_data4 !== 32'h33323130) begin
      n_err++;
      $display("FAIL missing_fs: got err=%b locked=%b valid=%b data=%h want 1/0/0000/33323130",
               err4, locked4, ch_valid4, ch_data4);
    end
    cyc4(8'h41, 1'b1, 1'b0);
    n_vec++;
    if (err4 !== 1'b0 || locked4 !== 1'b0 || ch_valid4 !== 4'b0000) begin
      n_err++;
      $display("FAIL missing_fs_hunt: got err=%b locked=%b valid=%b want 0/0/0000",
               err4, locked4, ch_valid4);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    cyc4(8'h60, 1'b1, 1'b1);
    cyc4(8'h61, 1'b1, 1'b0);
    rst = 1'b1;
    cyc4(8'h62, 1'b1, 1'b1);
    rst = 1'b0;
    n_vec++;
    if ({ch_data4, ch_valid4, done4, locked4, err4} !== 40'h0) begin
      n_err++;
      $display("FAIL mid_reset: got data=%h valid=%b done=%b locked=%b err=%b want all 0",
               ch_data4, ch_valid4, done4, locked4, err4);
    end
    cyc4(8'h70, 1'b1, 1'b1);
    n_vec++;
    if (ch_valid4 !== 4'b0001 || ch_data4 !== 32'h00000070 || locked4 !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset_relock: got valid=%b data=%h locked=%b want 0001/00000070/1",
               ch_valid4, ch_data4, locked4);
    end
  endtask

  task automatic test_back_to_back_nch3();
    logic [7:0] samples [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    logic [2:0] exp_v   [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    int         n_done;
    do_reset();
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      cyc3(samples[i], 1'b1, (i % 3) == 0);
      if (done3 === 1'b1) n_done++;
      n_vec++;
      if (ch_valid3 !== exp_v[i] || done3 !== ((i % 3) == 2) || err3 !== 1'b0) begin
        n_err++;
        $display("FAIL nch3_%0d: got valid=%b done=%b err=%b want valid=%b done=%b err=0",
                 i, ch_valid3, done3, err3, exp_v[i], (i % 3) == 2);
      end
    end
    n_vec++;
    if (n_done !== 2 || ch_data3 !== 24'h060504) begin
      n_err++;
      $display("FAIL nch3_summary: got done_pulses=%0d data=%h want 2/060504", n_done, ch_data3);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    d4 = '0; v4 = 1'b0; fs4 = 1'b0;
    d3 = '0; v3 = 1'b0; fs3 = 1'b0;
    test_reset();
    test_nominal();
    test_gaps();
    test_hunt_discard();
    test_early_fs();
    test_missing_fs();
    test_mid_reset();
    test_back_to_back_nch3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
